// File: rtl/block_render_pkg.sv
// Shared constants, types and helpers for the block renderer.
//   - Screen geometry: 20 x 15 blocks of 32 x 32 pixels.
//   - tile_id_t: tile identifier at the default 4-bit width.
//   - wr_state_e: states of the tile-map write handshake FSM.
//   - in_map(): true when a block index addresses a real map entry.
package block_render_pkg;

  localparam int unsigned BLOCKS_PER_ROW = 20;
  localparam int unsigned MAP_ROWS       = 15;
  localparam int unsigned MAP_BLOCKS     = BLOCKS_PER_ROW * MAP_ROWS;
  localparam int unsigned BLOCK_PX       = 32;
  localparam int unsigned INBLOCK_W      = $clog2(BLOCK_PX * BLOCK_PX);
  localparam int unsigned BLOCK_W        = 9;
  localparam int unsigned TILE_BITS_DEF  = 4;

  typedef logic [TILE_BITS_DEF-1:0] tile_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } wr_state_e;

  function automatic logic in_map(input logic [BLOCK_W-1:0] blk);
    return blk < BLOCK_W'(MAP_BLOCKS);
  endfunction

endpackage

// File: rtl/block_renderer_tile_map_ram.sv
// tile_map_ram: 300-entry tile-ID store, one entry per screen block.
// Ports:
//   clk        rising-edge clock
//   rd_en_i    read strobe; rd_tile_o updates on the next edge
//   rd_addr_i  block index to read (caller keeps it < 300 when enabled)
//   rd_tile_o  registered read data
//   wr_en_i    write strobe
//   wr_addr_i  block index to write (caller keeps it < 300 when enabled)
//   wr_tile_i  tile ID to store
// Contents are not reset.
module tile_map_ram
  import block_render_pkg::*;
#(
  parameter int TILE_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rd_en_i,
  input  logic [BLOCK_W-1:0]   rd_addr_i,
  output logic [TILE_BITS-1:0] rd_tile_o,
  input  logic                 wr_en_i,
  input  logic [BLOCK_W-1:0]   wr_addr_i,
  input  logic [TILE_BITS-1:0] wr_tile_i
);

  logic [TILE_BITS-1:0] mem [MAP_BLOCKS];
  logic [TILE_BITS-1:0] rd_tile_q;

  always_ff @(posedge clk) begin
    if (rd_en_i) rd_tile_q <= mem[rd_addr_i];
    if (wr_en_i) mem[wr_addr_i] <= wr_tile_i;
  end

  assign rd_tile_o = rd_tile_q;

endmodule

// File: rtl/block_renderer.sv
// block_renderer: turns (block_coord, inblock_coord) into a pixel colour via
// a tile map and an external synchronous tile-pixel ROM, and accepts tile-map
// updates over a 4-phase req/ack port that commits only during blanking.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   block_coord, inblock_coord pixel coordinates, qualified by pix_valid_in
//   pix_valid_in, vblank       active-pixel qualifier, vertical blank flag
//   rom_addr / rom_data        {tile_id, offset} to ROM, data one cycle later
//   pix_out, pix_valid_out     pixel colour, 2 edges after coord sampling
//   wr_req, wr_addr, wr_tile   tile-map write request (level, held to ack)
//   wr_ack                     write acknowledge (level)
// Build option: BLOCK_RENDERER_VSYNC_COMMIT_EN restricts map commits to
// vertical blanking so the map only changes between frames.
module block_renderer
  import block_render_pkg::*;
#(
  parameter int                  TILE_BITS     = 4,
  parameter int                  PIX_BITS      = 8,
  parameter logic [PIX_BITS-1:0] BORDER_COLOUR = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BLOCK_W-1:0]            block_coord,
  input  logic [INBLOCK_W-1:0]          inblock_coord,
  input  logic                          pix_valid_in,
  input  logic                          vblank,
  output logic [TILE_BITS+INBLOCK_W-1:0] rom_addr,
  input  logic [PIX_BITS-1:0]           rom_data,
  output logic [PIX_BITS-1:0]           pix_out,
  output logic                          pix_valid_out,
  input  logic                          wr_req,
  input  logic [BLOCK_W-1:0]            wr_addr,
  input  logic [TILE_BITS-1:0]          wr_tile,
  output logic                          wr_ack
);

  logic                 blk_in_map;
  logic                 rd_en;
  logic [TILE_BITS-1:0] tile_rd;
  logic [TILE_BITS-1:0] tile_field;

  logic                 vld_p0, oor_p0;
  logic [INBLOCK_W-1:0] ib_p0;
  logic                 vld_p1, oor_p1;
  logic [PIX_BITS-1:0]  pix_q;
  logic                 pix_vld_q;

  wr_state_e            state_q;
  logic [BLOCK_W-1:0]   pend_addr_q;
  logic [TILE_BITS-1:0] pend_tile_q;
  logic                 wr_ack_q;
  logic                 commit_win;
  logic                 map_we;

  assign blk_in_map = in_map(block_coord);
  // Reads only for valid in-range pixels, so a read never shares a cycle with
  // a commit (commits need pix_valid_in low).
  assign rd_en = pix_valid_in && blk_in_map;

  tile_map_ram #(.TILE_BITS(TILE_BITS)) u_map (
    .clk       (clk),
    .rd_en_i   (rd_en),
    .rd_addr_i (block_coord),
    .rd_tile_o (tile_rd),
    .wr_en_i   (map_we),
    .wr_addr_i (pend_addr_q),
    .wr_tile_i (pend_tile_q)
  );

  // ---- S1: map read issued, coords and flags registered ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      oor_p0 <= 1'b0;
      ib_p0  <= '0;
    end else begin
      vld_p0 <= pix_valid_in;
      oor_p0 <= !blk_in_map;
      ib_p0  <= inblock_coord;
    end
  end

  // The RAM output is only meaningful after an in-range valid read; zeroing
  // the tile field otherwise keeps rom_addr defined out of reset and for the
  // border region.
  assign tile_field = (vld_p0 && !oor_p0) ? tile_rd : '0;
  assign rom_addr   = {tile_field, ib_p0};

  // ---- S2: ROM registers its data; flags follow ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      oor_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      oor_p1 <= oor_p0;
    end
  end

  // ---- S3: colour select ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      pix_vld_q <= vld_p1;
      if (!vld_p1)     pix_q <= '0;
      else if (oor_p1) pix_q <= BORDER_COLOUR;
      else             pix_q <= rom_data;
    end
  end

  assign pix_out       = pix_q;
  assign pix_valid_out = pix_vld_q;

`ifdef BLOCK_RENDERER_VSYNC_COMMIT_EN
  assign commit_win = vblank && !pix_valid_in;
`else
  assign commit_win = !pix_valid_in;
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  // Out-of-range targets run the full handshake but never touch the map.
  assign map_we = (state_q == HOLD) && commit_win && in_map(pend_addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ack_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_tile_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (wr_req) begin
          pend_addr_q <= wr_addr;
          pend_tile_q <= wr_tile;
          state_q     <= HOLD;
        end
        HOLD: if (commit_win) begin
          state_q  <= ACK;
          wr_ack_q <= 1'b1;
        end
        ACK: if (!wr_req) begin
          state_q  <= IDLE;
          wr_ack_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          wr_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_block_renderer.sv
module tb_block_renderer;

  localparam logic [7:0] BORDER = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  block_coord = '0;
  logic [9:0]  inblock_coord = '0;
  logic        pix_valid_in = 1'b0;
  logic        vblank = 1'b0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  pix_out;
  logic        pix_valid_out;
  logic        wr_req = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [3:0]  wr_tile = '0;
  logic        wr_ack;

  always #5 clk = ~clk;

  block_renderer #(.TILE_BITS(4), .PIX_BITS(8), .BORDER_COLOUR(BORDER)) dut (
    .clk(clk), .rst_n(rst_n),
    .block_coord(block_coord), .inblock_coord(inblock_coord),
    .pix_valid_in(pix_valid_in), .vblank(vblank),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_out(pix_out), .pix_valid_out(pix_valid_out),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_tile(wr_tile), .wr_ack(wr_ack)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Tile-pixel ROM: returns the low byte of the address one cycle later.
  // addr_used is the address the ROM saw for the pixel now on pix_out.
  logic [13:0] addr_at_rom = '0, addr_used = '0;
  always @(posedge clk) begin
    rom_data    <= rom_addr[7:0];
    addr_at_rom <= rom_addr;
    addr_used   <= addr_at_rom;
  end

  // Reference model of the map, updated when an ack proves a commit happened.
  int map_model [300];
  int pend_a = 0, pend_t = 0;
  int commit_cnt = 0;
  bit ack_prev = 1'b0;
  always begin
    @(posedge clk); #1;
    if (rst_n && wr_ack && !ack_prev) begin
      commit_cnt++;
      if (pend_a < 300) map_model[pend_a] = pend_t;
    end
    ack_prev = rst_n && wr_ack;
  end

  typedef struct { int pix; int addr; int due; } item_t;
  item_t sb_q [$];

  // Pixel driver: 0 blank, 1 random with gaps, 2 all valid random,
  // 3 fixed coords, 4 sweep of blocks.
  int drv_mode = 0;
  int fix_blk = 0, fix_ib = 0, sweep_blk = 0;
  always @(negedge clk) begin : drv
    bit v;
    int b, ib;
    item_t it;
    v = 1'b0;
    b = int'($urandom_range(0, 511));
    ib = int'($urandom_range(0, 1023));
    case (drv_mode)
      1: begin
        v = ($urandom_range(0, 9) < 7);
        b = ($urandom_range(0, 9) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 299));
      end
      2: begin
        v = 1'b1;
        b = ($urandom_range(0, 9) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 299));
      end
      3: begin v = 1'b1; b = fix_blk; ib = fix_ib; end
      4: begin v = 1'b1; b = sweep_blk; sweep_blk++; end
      default: ;
    endcase
    pix_valid_in  = v;
    block_coord   = 9'(b);
    inblock_coord = 10'(ib);
    vblank        = (drv_mode == 0);
    if (v) begin
      it.pix  = (b >= 300) ? int'(BORDER) : (ib % 256);
      it.addr = ((b < 300) ? map_model[b] * 1024 : 0) + ib;
      it.due  = cyc + 3;
      sb_q.push_back(it);
    end
  end

  // Monitor: pops the oldest expectation whenever a pixel is presented.
  always @(negedge clk) begin : mon
    item_t it;
    if (rst_n) begin
      if (pix_valid_out) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pixel", 1'b0, pix_out, -1);
        end else begin
          it = sb_q.pop_front();
          checks++;
          if (!(int'(pix_out) == it.pix && int'(addr_used) == it.addr && cyc == it.due)) begin
            errors++;
            $display("FAIL pixel: got pix=%0h addr=%0h cyc=%0d required pix=%0h addr=%0h cyc=%0d",
                     pix_out, addr_used, cyc, it.pix, it.addr, it.due);
          end
        end
      end else begin
        chk("idle_pix_zero", pix_out == 8'h00, pix_out, 0);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_write(input int a, input int t, input int hold_after,
                          output int t2a, output int t2d);
    pend_a = a; pend_t = t;
    wr_addr = 9'(a); wr_tile = 4'(t); wr_req = 1'b1;
    t2a = 0;
    forever begin
      @(posedge clk); #1;
      t2a++;
      if (wr_ack) break;
      if (t2a > 3000) begin t2a = -1; break; end
    end
    #1;
    repeat (hold_after) begin
      wr_tile = ~4'(t);
      @(posedge clk); #1;
      chk("ack_held", wr_ack == 1'b1, wr_ack, 1);
      #1;
    end
    wr_req = 1'b0;
    t2d = 0;
    forever begin
      @(posedge clk); #1;
      t2d++;
      if (!wr_ack) break;
      if (t2d > 10) begin t2d = -1; break; end
    end
    #1;
  endtask

  task automatic read_one(input int b, input int ib, input int exp_addr);
    fix_blk = b; fix_ib = ib; drv_mode = 3;
    @(posedge clk); #1;
    chk("rom_addr_s1", rom_addr == exp_addr[13:0], rom_addr, exp_addr);
    drv_mode = 0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t2a, t2d, t, c0;
    bit seen;
    cyc_wait(3);
    chk("rst_pix_valid_out", pix_valid_out == 1'b0, pix_valid_out, 0);
    chk("rst_pix_out", pix_out == 8'h00, pix_out, 0);
    chk("rst_wr_ack", wr_ack == 1'b0, wr_ack, 0);
    chk("rst_rom_addr", rom_addr == 14'h0, rom_addr, 0);
    rst_n = 1'b1;
    cyc_wait(2);

    // Fill the whole map in blanking: ack must follow after exactly 2 edges.
    for (int i = 0; i < 300; i++) begin
      t = (i == 0) ? 3 : (i == 21) ? 2 : (i == 50) ? 6 : (i == 77) ? 4 : int'($urandom_range(0, 15));
      do_write(i, t, 0, t2a, t2d);
      chk("fill_ack_latency", t2a == 2, t2a, 2);
      chk("fill_ack_drop", t2d == 1, t2d, 1);
    end

    // Basic lookup and border.
    read_one(0, 5, 3 * 1024 + 5);
    read_one(300, 7, 7);
    cyc_wait(4);

    // Write held off through an active stretch, commits on first blank edge.
    drv_mode = 2;
    cyc_wait(2);
    pend_a = 21; pend_t = 9;
    wr_addr = 9'd21; wr_tile = 4'd9; wr_req = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wr_ack) seen = 1'b1;
      #1;
    end
    chk("ack_during_active", !seen, seen, 0);
    drv_mode = 0;
    @(posedge clk); #1;
    chk("ack_first_blank", wr_ack == 1'b1, wr_ack, 1);
    #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop_21", wr_ack == 1'b0, wr_ack, 0);
    #1;
    read_one(21, 33, 9 * 1024 + 33);
    cyc_wait(3);

    // Request held 5 cycles past ack, with tile changed after ack.
    c0 = commit_cnt;
    do_write(77, 12, 5, t2a, t2d);
    chk("hold_ack_latency", t2a == 2, t2a, 2);
    chk("hold_ack_drop", t2d == 1, t2d, 1);
    chk("hold_one_commit", commit_cnt - c0 == 1, commit_cnt - c0, 1);
    cyc_wait(3);
    read_one(77, 1, 12 * 1024 + 1);
    cyc_wait(3);

    // Out-of-range writes: acknowledged, map untouched.
    do_write(400, 7, 0, t2a, t2d);
    chk("oor400_ack", t2a == 2, t2a, 2);
    chk("oor400_drop", t2d == 1, t2d, 1);
    do_write(300, 5, 0, t2a, t2d);
    chk("oor300_ack", t2a == 2, t2a, 2);
    sweep_blk = 0;
    drv_mode = 4;
    cyc_wait(300);
    drv_mode = 0;
    cyc_wait(4);

    // Reset while the write waits in HOLD.
    drv_mode = 2;
    cyc_wait(1);
    pend_a = 50; pend_t = 13;
    wr_addr = 9'd50; wr_tile = 4'd13; wr_req = 1'b1;
    cyc_wait(3);
    rst_n = 1'b0; wr_req = 1'b0; drv_mode = 0;
    sb_q.delete();
    #1;
    chk("mid_rst_pix_valid_out", pix_valid_out == 1'b0, pix_valid_out, 0);
    chk("mid_rst_pix_out", pix_out == 8'h00, pix_out, 0);
    chk("mid_rst_rom_addr", rom_addr == 14'h0, rom_addr, 0);
    chk("mid_rst_wr_ack", wr_ack == 1'b0, wr_ack, 0);
    cyc_wait(2);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wr_ack) seen = 1'b1;
      #1;
    end
    chk("no_ack_after_rst", !seen, seen, 0);
    read_one(50, 9, 6 * 1024 + 9);
    cyc_wait(3);

    // Random traffic with interleaved writes.
    drv_mode = 1;
    for (int w = 0; w < 8; w++) begin
      do_write(int'($urandom_range(0, 299)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), t2a, t2d);
      chk("rand_ack_done", t2a > 0, t2a, 1);
      chk("rand_ack_drop", t2d == 1, t2d, 1);
      cyc_wait(int'($urandom_range(1, 20)));
    end
    drv_mode = 0;
    cyc_wait(6);
    chk("scoreboard_empty", sb_q.size() == 0, sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
